// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the data-memory bus bridge.
package mips_mem_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_RSP  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // Load data returned when an access is refused or aborted.
  localparam logic [DEF_DATA_W-1:0] RDATA_ERR = 32'h0;

  function automatic logic word_aligned(input logic [1:0] byte_off);
    return byte_off == 2'b00;
  endfunction

endpackage

// File: rtl/dmem_bus_bridge_if.sv
// req/gnt/rvalid memory bus between the bridge (master) and the memory (slave).
interface dmem_bus_bridge_if
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) ();

  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_gnt;
  logic              bus_rvalid;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    input  bus_gnt,
    input  bus_rvalid,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    output bus_gnt,
    output bus_rvalid,
    output bus_rdata
  );

endinterface

// File: rtl/bus_timeout_ctr.sv
// Counts REQ/RSP cycles of one bus transaction; flags the cycle in which the count reaches TIMEOUT.
module bus_timeout_ctr #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // The TIMEOUT-th counted cycle is the last one the transaction may occupy.
  assign expired_c = enable && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/dmem_bus_bridge.sv
// Turns the datapath's single-cycle load/store into a req/gnt/rvalid bus transaction,
// stalling the core until the response (or a timeout) arrives.
module dmem_bus_bridge
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              misalign_err,
  output logic              timeout_err,
  dmem_bus_bridge_if.master bus
);

  state_t            state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              misalign_q, misalign_d;
  logic              timeout_q, timeout_d;
  logic              access_c;
  logic              ctr_clear;
  logic              ctr_en;
  logic              expired_c;

  // A store with mem_read also high is still a single write.
  assign access_c = mem_read | mem_write;

  bus_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (ctr_clear),
    .enable    (ctr_en),
    .expired_c (expired_c)
  );

  // Next-state, stall and register-update logic.
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    misalign_d  = 1'b0;
    timeout_d   = timeout_q;
    stall       = 1'b0;
    ctr_clear   = 1'b0;
    ctr_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Core held in reset must not see a stall from a stale access.
        if (rst_n && access_c) begin
          if (word_aligned(addr[1:0])) begin
            stall       = 1'b1;
            ctr_clear   = 1'b1;
            bus_req_d   = 1'b1;
            bus_we_d    = mem_write;
            bus_addr_d  = {addr[ADDR_W-1:2], 2'b00};
            bus_wdata_d = wdata;
            state_d     = ST_REQ;
          end else begin
            misalign_d = 1'b1;
            rdata_d    = DATA_W'(RDATA_ERR);
          end
        end
      end

      ST_REQ: begin
        stall  = 1'b1;
        ctr_en = 1'b1;
        if (expired_c) begin
          bus_req_d = 1'b0;
          rdata_d   = DATA_W'(RDATA_ERR);
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end else if (bus.bus_gnt) begin
          bus_req_d = 1'b0;
          if (bus.bus_rvalid) begin
            if (!bus_we_q) begin
              rdata_d = bus.bus_rdata;
            end
            state_d = ST_DONE;
          end else begin
            state_d = ST_RSP;
          end
        end
      end

      ST_RSP: begin
        stall  = 1'b1;
        ctr_en = 1'b1;
        // Abort takes priority over a response landing in the same cycle.
        if (expired_c) begin
          rdata_d   = DATA_W'(RDATA_ERR);
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end else if (bus.bus_rvalid) begin
          if (!bus_we_q) begin
            rdata_d = bus.bus_rdata;
          end
          state_d = ST_DONE;
        end
      end

      // The access still visible here belongs to the finishing instruction.
      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      misalign_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      misalign_q  <= misalign_d;
      timeout_q   <= timeout_d;
    end
  end

  assign rdata         = rdata_q;
  assign misalign_err  = misalign_q;
  assign timeout_err   = timeout_q;
  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Directed bench for dmem_bus_bridge: table of bus transactions plus reset corner cases.
module tb_dmem_bus_bridge;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 8;
  localparam int          NV  = 13;

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            gnt_dly;   // index of the bus_req cycle that gets bus_gnt (99 = never)
    int            rv_dly;    // cycles from gnt to rvalid (99 = never)
    logic [DW-1:0] bus_rd;
    int            exp_stall;
    int            exp_req;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    logic [DW-1:0] exp_rdata;
    logic          exp_mis;
    logic          exp_tmo;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          stall;
  logic          misalign_err;
  logic          timeout_err;

  int n_tests;
  int n_fail;

  vec_t vecs [NV];
  vec_t rec;

  dmem_bus_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

  dmem_bus_bridge #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .stall        (stall),
    .misalign_err (misalign_err),
    .timeout_err  (timeout_err),
    .bus          (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_bus_idle();
    bus_if.bus_gnt    = 1'b0;
    bus_if.bus_rvalid = 1'b0;
    bus_if.bus_rdata  = 32'hEEEE_EEEE;
  endtask

  // Present one access, play the memory side, then check the outcome and the following idle cycles.
  task automatic run_txn(input vec_t v, input string tag);
    int            stall_cnt = 0;
    int            req_cnt   = 0;
    int            gnt_cyc   = -1;
    bit            done      = 1'b0;
    bit            stable    = 1'b1;
    logic [AW-1:0] ref_addr  = '0;
    logic [DW-1:0] ref_wdata = '0;
    logic          ref_we    = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (c == 0) begin
        mem_read  = v.rd;
        mem_write = v.wr;
        addr      = v.addr;
        wdata     = v.wdata;
      end
      drive_bus_idle();
      if (bus_if.bus_req) begin
        if (req_cnt == 0) begin
          ref_addr  = bus_if.bus_addr;
          ref_wdata = bus_if.bus_wdata;
          ref_we    = bus_if.bus_we;
        end else if (bus_if.bus_addr !== ref_addr || bus_if.bus_wdata !== ref_wdata ||
                     bus_if.bus_we !== ref_we) begin
          stable = 1'b0;
        end
        if (req_cnt == v.gnt_dly) begin
          bus_if.bus_gnt = 1'b1;
          gnt_cyc        = c;
        end
        req_cnt++;
      end
      if (gnt_cyc >= 0 && c == gnt_cyc + v.rv_dly) begin
        bus_if.bus_rvalid = 1'b1;
        bus_if.bus_rdata  = v.bus_rd;
      end
      #1;
      if (stall) stall_cnt++;
      else done = 1'b1;
    end
    check({tag, ".done"},        32'(done),             32'd1);
    check({tag, ".stall_cyc"},   32'(stall_cnt),        32'(v.exp_stall));
    check({tag, ".req_cyc"},     32'(req_cnt),          32'(v.exp_req));
    check({tag, ".req_stable"},  32'(stable),           32'd1);
    check({tag, ".bus_we"},      32'(bus_if.bus_we),    32'(v.exp_we));
    check({tag, ".bus_addr"},    bus_if.bus_addr,       v.exp_addr);
    check({tag, ".bus_wdata"},   bus_if.bus_wdata,      v.exp_wdata);
    if (v.exp_stall > 0) check({tag, ".rdata_done"}, rdata, v.exp_rdata);

    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    drive_bus_idle();
    #1;
    check({tag, ".post_req"},    32'(bus_if.bus_req),   32'd0);
    check({tag, ".post_stall"},  32'(stall),            32'd0);
    check({tag, ".post_rdata"},  rdata,                 v.exp_rdata);
    check({tag, ".misalign"},    32'(misalign_err),     32'(v.exp_mis));
    check({tag, ".timeout"},     32'(timeout_err),      32'(v.exp_tmo));
    @(negedge clk);
    #1;
    check({tag, ".mis_clear"},   32'(misalign_err),     32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr      = '0;
    wdata     = '0;
    drive_bus_idle();

    //          rd    wr    addr        wdata         g   r   bus_rd        st rq we    exp_addr    exp_wdata     exp_rdata     mis   tmo
    vecs[0]  = '{1'b1, 1'b0, 32'h10,  32'h0,        0,  1,  32'hCAFEF00D, 3, 1, 1'b0, 32'h10,  32'h0,        32'hCAFEF00D, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 32'h20,  32'h12345678, 4,  1,  32'hDEADBEEF, 7, 5, 1'b1, 32'h20,  32'h12345678, 32'hCAFEF00D, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 32'h13,  32'hFFFF0000, 0,  0,  32'h0,        0, 0, 1'b1, 32'h20,  32'h12345678, 32'h0,        1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 32'h40,  32'hA5A5A5A5, 0,  0,  32'h11111111, 2, 1, 1'b1, 32'h40,  32'hA5A5A5A5, 32'h0,        1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'h44,  32'h0,        0,  0,  32'h0BADF00D, 2, 1, 1'b0, 32'h44,  32'h0,        32'h0BADF00D, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'h100, 32'h0,        2,  3,  32'h76543210, 7, 3, 1'b0, 32'h100, 32'h0,        32'h76543210, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'h80,  32'h0,        0,  6,  32'h89ABCDEF, 8, 1, 1'b0, 32'h80,  32'h0,        32'h89ABCDEF, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 32'h22,  32'h5555AAAA, 0,  0,  32'h0,        0, 0, 1'b0, 32'h80,  32'h0,        32'h0,        1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 32'h3C,  32'h77,       0,  0,  32'h0,        0, 0, 1'b0, 32'h80,  32'h0,        32'h0,        1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 32'h84,  32'h0,        0,  0,  32'h13579BDF, 2, 1, 1'b0, 32'h84,  32'h0,        32'h13579BDF, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'h300, 32'h0,        0,  7,  32'h2468ACE0, 9, 1, 1'b0, 32'h300, 32'h0,        32'h0,        1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 32'h88,  32'h0,        0,  1,  32'h0F0F0F0F, 3, 1, 1'b0, 32'h88,  32'h0,        32'h0F0F0F0F, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 32'h200, 32'h0,        99, 99, 32'h0,        9, 8, 1'b0, 32'h200, 32'h0,        32'h0,        1'b0, 1'b1};
    rec      = '{1'b1, 1'b0, 32'h60,  32'h0,        0,  1,  32'hA1B2C3D4, 3, 1, 1'b0, 32'h60,  32'h0,        32'hA1B2C3D4, 1'b0, 1'b0};

    // Reset values.
    repeat (3) @(negedge clk);
    #1;
    check("reset.rdata",     rdata,                     32'h0);
    check("reset.stall",     32'(stall),                32'd0);
    check("reset.bus_req",   32'(bus_if.bus_req),       32'd0);
    check("reset.bus_we",    32'(bus_if.bus_we),        32'd0);
    check("reset.bus_addr",  bus_if.bus_addr,           32'h0);
    check("reset.bus_wdata", bus_if.bus_wdata,          32'h0);
    check("reset.misalign",  32'(misalign_err),         32'd0);
    check("reset.timeout",   32'(timeout_err),          32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset while a request is outstanding.
    @(negedge clk);
    mem_read = 1'b1;
    addr     = 32'h50;
    wdata    = 32'h0;
    @(negedge clk);
    #1;
    check("rst_req.req_before", 32'(bus_if.bus_req), 32'd1);
    #2;
    rst_n    = 1'b0;
    mem_read = 1'b0;
    #1;
    check("rst_req.bus_req",  32'(bus_if.bus_req), 32'd0);
    check("rst_req.stall",    32'(stall),          32'd0);
    check("rst_req.timeout",  32'(timeout_err),    32'd0);
    check("rst_req.bus_addr", bus_if.bus_addr,     32'h0);
    @(negedge clk);
    rst_n             = 1'b1;
    bus_if.bus_gnt    = 1'b1;
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata  = 32'hFFFFFFFF;
    #1;
    check("rst_req.late_stall", 32'(stall), 32'd0);
    @(negedge clk);
    drive_bus_idle();
    #1;
    check("rst_req.late_req",   32'(bus_if.bus_req), 32'd0);
    check("rst_req.late_rdata", rdata,               32'h0);

    // Reset while waiting for the response.
    @(negedge clk);
    mem_read = 1'b1;
    addr     = 32'h54;
    @(negedge clk);
    bus_if.bus_gnt = bus_if.bus_req;
    @(negedge clk);
    bus_if.bus_gnt = 1'b0;
    #1;
    check("rst_rsp.stall_before", 32'(stall),          32'd1);
    check("rst_rsp.req_before",   32'(bus_if.bus_req), 32'd0);
    #2;
    rst_n    = 1'b0;
    mem_read = 1'b0;
    #1;
    check("rst_rsp.stall",    32'(stall),          32'd0);
    check("rst_rsp.bus_req",  32'(bus_if.bus_req), 32'd0);
    check("rst_rsp.bus_addr", bus_if.bus_addr,     32'h0);
    @(negedge clk);
    rst_n             = 1'b1;
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata  = 32'h12121212;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("rst_rsp.late_rdata%0d", k), rdata,               32'h0);
      check($sformatf("rst_rsp.late_stall%0d", k), 32'(stall),          32'd0);
      check($sformatf("rst_rsp.late_req%0d", k),   32'(bus_if.bus_req), 32'd0);
    end
    drive_bus_idle();

    run_txn(rec, "recover");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
